// File: rtl/endec_frame_packer_pkg.sv
// Shared definitions for the serial-symbol to decoder-frame packer.
package endec_frame_packer_pkg;

  localparam int unsigned FRAME_BITS_DEF = 276;
  localparam int unsigned MAX_CODE_RATE  = 3;

  // Encoding of i_code_rate
  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

endpackage

// File: rtl/endec_frame_packer.sv
// Packs 2- or 3-bit serial symbols LSB-first into one wide frame and holds it
// behind a valid/ready handshake until the Viterbi decoder takes it.
module endec_frame_packer
  import endec_frame_packer_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned SYM_W      = MAX_CODE_RATE,
  parameter int unsigned CNT_W      = $clog2(FRAME_BITS / 2 + 1),
  parameter int unsigned LEN_W      = $clog2(FRAME_BITS + 1)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  i_code_rate,
  input  logic                  i_sym_valid,
  input  logic [SYM_W-1:0]      i_sym_data,
  output logic                  o_sym_ready,
  input  logic                  i_flush,
  output logic [FRAME_BITS-1:0] o_frame_data,
  output logic [LEN_W-1:0]      o_frame_len,
  output logic                  o_frame_valid,
  input  logic                  i_frame_ready
);

  packer_state_e         state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  rate3_q, rate3_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  sym_ready_q, sym_ready_d;
  logic                  frame_valid_q, frame_valid_d;

  logic                  accept_c;
  logic                  rate3_c;
  logic [LEN_W-1:0]      n_c;
  logic [LEN_W-1:0]      off_c;
  logic [LEN_W-1:0]      fill_c;
  logic [SYM_W-1:0]      sym_c;

  // Next-state, symbol write and frame close logic
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rate3_d       = rate3_q;
    data_d        = data_q;
    len_d         = len_q;
    fill_c        = '0;

    accept_c = i_sym_valid && sym_ready_q;
    // Rate is taken live only for the first symbol of a frame, latched after
    rate3_c  = (count_q == '0) ? (i_code_rate != CODE_RATE_2) : rate3_q;
    n_c      = rate3_c ? LEN_W'(3) : LEN_W'(2);
    off_c    = LEN_W'(count_q) * n_c;
    sym_c    = i_sym_data & (rate3_c ? SYM_W'(7) : SYM_W'(3));

    case (state_q)
      FILL: begin
        if (accept_c) begin
          rate3_d = rate3_c;
          count_d = count_q + CNT_W'(1);
          data_d  = data_q | (FRAME_BITS'(sym_c) << off_c);
        end
        fill_c = LEN_W'(count_d) * n_c;
        if ((fill_c == LEN_W'(FRAME_BITS)) || (i_flush && (count_d != '0))) begin
          state_d = HOLD;
          len_d   = fill_c;
        end
      end
      HOLD: begin
        if (i_frame_ready) begin
          state_d = FILL;
          count_d = '0;
          data_d  = '0;
          len_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    sym_ready_d   = (state_d == FILL);
    frame_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q       <= FILL;
      count_q       <= '0;
      rate3_q       <= 1'b0;
      data_q        <= '0;
      len_q         <= '0;
      sym_ready_q   <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rate3_q       <= rate3_d;
      data_q        <= data_d;
      len_q         <= len_d;
      sym_ready_q   <= sym_ready_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign o_sym_ready   = sym_ready_q;
  assign o_frame_valid = frame_valid_q;
  assign o_frame_data  = data_q;
  assign o_frame_len   = len_q;

endmodule

// File: tb/tb_endec_frame_packer.sv
// Self-checking bench for endec_frame_packer against a queue-based frame model.
module tb_endec_frame_packer;
  import endec_frame_packer_pkg::*;

  localparam int unsigned FB    = 276;
  localparam int unsigned LEN_W = 9;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             i_code_rate;
  logic             i_sym_valid;
  logic [2:0]       i_sym_data;
  logic             o_sym_ready;
  logic             i_flush;
  logic [FB-1:0]    o_frame_data;
  logic [LEN_W-1:0] o_frame_len;
  logic             o_frame_valid;
  logic             i_frame_ready;

  int errors = 0;
  int checks = 0;

  // Behavioural model: accepted symbols of the open frame kept in a queue
  logic [2:0]    m_q[$];
  int            m_n;
  logic          m_hold, m_ready, m_valid;
  logic [FB-1:0] m_data;
  int            m_len;
  int            m_acc;

  endec_frame_packer dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .i_code_rate  (i_code_rate),
    .i_sym_valid  (i_sym_valid),
    .i_sym_data   (i_sym_data),
    .o_sym_ready  (o_sym_ready),
    .i_flush      (i_flush),
    .o_frame_data (o_frame_data),
    .o_frame_len  (o_frame_len),
    .o_frame_valid(o_frame_valid),
    .i_frame_ready(i_frame_ready)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [FB-1:0] model_frame();
    logic [FB-1:0] f;
    f = '0;
    for (int k = 0; k < m_q.size(); k++)
      for (int b = 0; b < m_n; b++)
        f[k*m_n+b] = m_q[k][b];
    return f;
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_hold = 1'b0; m_q.delete(); m_ready = 1'b0; m_valid = 1'b0;
      m_len = 0; m_data = '0;
      return;
    end
    if (!m_hold) begin
      if (i_sym_valid && m_ready) begin
        if (m_q.size() == 0) m_n = (i_code_rate == CODE_RATE_2) ? 2 : 3;
        m_q.push_back(i_sym_data);
        m_acc++;
      end
      if (m_q.size() > 0 && ((m_q.size() * m_n) == FB || i_flush)) begin
        m_hold = 1'b1;
        m_len  = m_q.size() * m_n;
        m_data = model_frame();
      end
    end else if (i_frame_ready) begin
      m_hold = 1'b0;
      m_q.delete();
    end
    m_ready = !m_hold;
    m_valid = m_hold;
  endfunction

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_frame_valid); end
    checks++; if (o_sym_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", o_sym_ready); end
    checks++; if (o_frame_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_frame_data); end
    checks++; if (o_frame_len !== '0) begin errors++; $display("FAIL reset_len got=%0d exp=0", o_frame_len); end
    rst = 1'b0;
    tick();
    checks++; if (o_sym_ready !== m_ready || m_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", o_sym_ready); end
  endtask

  task automatic test_full_rate2();
    logic [FB-1:0] exp_d;
    int start, hold_cycles;
    bit seen;
    exp_d = {138{2'b10}};
    start = m_acc; hold_cycles = 0; seen = 0;
    i_code_rate = CODE_RATE_2; i_frame_ready = 1'b1;
    for (int cyc = 0; cyc < 145; cyc++) begin
      i_sym_valid = (m_acc - start) < 138;
      i_sym_data  = 3'b110;
      tick();
      checks++; if (o_sym_ready !== m_ready) begin errors++; $display("FAIL full2_ready cyc=%0d got=%b exp=%b", cyc, o_sym_ready, m_ready); end
      checks++; if (o_frame_valid !== m_valid) begin errors++; $display("FAIL full2_valid cyc=%0d got=%b exp=%b", cyc, o_frame_valid, m_valid); end
      if (m_valid) begin
        hold_cycles++;
        checks++; if (cyc != 137) begin errors++; $display("FAIL full2_latency got_cyc=%0d exp_cyc=137", cyc); end
        checks++; if (o_frame_data !== exp_d) begin errors++; $display("FAIL full2_data got=%h exp=%h", o_frame_data, exp_d); end
        checks++; if (o_frame_len !== LEN_W'(276)) begin errors++; $display("FAIL full2_len got=%0d exp=276", o_frame_len); end
        seen = 1;
      end
    end
    i_sym_valid = 1'b0;
    checks++; if (!seen || hold_cycles != 1) begin errors++; $display("FAIL full2_hold_cycles got=%0d exp=1", hold_cycles); end
  endtask

  task automatic test_hold_rate3();
    logic [FB-1:0] exp_d;
    int start;
    bit seen;
    exp_d = {92{3'b101}};
    start = m_acc; seen = 0;
    i_code_rate = CODE_RATE_3; i_frame_ready = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      i_sym_valid = (m_acc - start) < 92;
      i_sym_data  = 3'b101;
      tick();
      checks++; if (o_frame_valid !== m_valid) begin errors++; $display("FAIL hold3_valid cyc=%0d got=%b exp=%b", cyc, o_frame_valid, m_valid); end
      seen = m_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold3_timeout got=no_frame exp=frame"); end
    checks++; if (o_frame_data !== exp_d) begin errors++; $display("FAIL hold3_data got=%h exp=%h", o_frame_data, exp_d); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      i_sym_valid = 1'b1;
      i_sym_data  = 3'($urandom);
      i_code_rate = 1'($urandom);
      tick();
      checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL hold3_stay_valid cyc=%0d got=%b exp=1", cyc, o_frame_valid); end
      checks++; if (o_sym_ready !== 1'b0) begin errors++; $display("FAIL hold3_ready cyc=%0d got=%b exp=0", cyc, o_sym_ready); end
      checks++; if (o_frame_data !== exp_d) begin errors++; $display("FAIL hold3_stable cyc=%0d got=%h exp=%h", cyc, o_frame_data, exp_d); end
      checks++; if (o_frame_len !== LEN_W'(276)) begin errors++; $display("FAIL hold3_len cyc=%0d got=%0d exp=276", cyc, o_frame_len); end
    end
    i_sym_valid = 1'b0; i_frame_ready = 1'b1;
    tick();
    i_frame_ready = 1'b0;
    checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL hold3_xfer_valid got=%b exp=0", o_frame_valid); end
    checks++; if (o_sym_ready !== 1'b1) begin errors++; $display("FAIL hold3_xfer_ready got=%b exp=1", o_sym_ready); end
  endtask

  task automatic test_flush_pattern();
    logic [2:0]    syms[8];
    logic [FB-1:0] exp_d;
    syms = '{3'd3, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd2};
    exp_d = {260'b0, 16'b1001101010100111};
    i_code_rate = CODE_RATE_2; i_frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_sym_valid = 1'b1; i_sym_data = syms[i]; i_flush = (i == 7);
      tick();
    end
    i_sym_valid = 1'b0; i_flush = 1'b0;
    checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got=%b exp=1", o_frame_valid); end
    checks++; if (o_frame_len !== LEN_W'(16)) begin errors++; $display("FAIL flush_len got=%0d exp=16", o_frame_len); end
    checks++; if (o_frame_data !== exp_d || m_data !== exp_d) begin errors++; $display("FAIL flush_data got=%h exp=%h", o_frame_data, exp_d); end
    i_frame_ready = 1'b1;
    tick();
    i_frame_ready = 1'b0;
  endtask

  task automatic test_flush_empty_latch();
    i_flush = 1'b1; i_sym_valid = 1'b0;
    tick();
    i_flush = 1'b0;
    checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_valid got=%b exp=0", o_frame_valid); end
    tick();
    checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_valid2 got=%b exp=0", o_frame_valid); end
    i_code_rate = CODE_RATE_2;
    for (int i = 0; i < 5; i++) begin
      i_sym_valid = 1'b1; i_sym_data = 3'($urandom);
      tick();
    end
    i_sym_valid = 1'b0; i_code_rate = CODE_RATE_3; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++; if (o_frame_len !== LEN_W'(10)) begin errors++; $display("FAIL latch_len got=%0d exp=10", o_frame_len); end
    checks++; if (o_frame_data !== m_data) begin errors++; $display("FAIL latch_data got=%h exp=%h", o_frame_data, m_data); end
    i_frame_ready = 1'b1;
    tick();
    i_frame_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [FB-1:0] exp_d;
    int start;
    bit seen;
    exp_d = {138{2'b01}};
    i_code_rate = CODE_RATE_2; i_frame_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      i_sym_valid = 1'b1; i_sym_data = 3'($urandom);
      tick();
    end
    i_sym_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    start = m_acc; seen = 0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      i_sym_valid = (m_acc - start) < 138;
      i_sym_data  = 3'b001;
      tick();
      seen = m_valid;
    end
    i_sym_valid = 1'b0;
    checks++; if (o_frame_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got=%b exp=1", o_frame_valid); end
    checks++; if (o_frame_data !== exp_d) begin errors++; $display("FAIL rstmid_data got=%h exp=%h", o_frame_data, exp_d); end
    checks++; if (o_frame_len !== LEN_W'(276)) begin errors++; $display("FAIL rstmid_len got=%0d exp=276", o_frame_len); end
    rst = 1'b1;
    tick();
    checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("FAIL rst_in_hold_valid got=%b exp=0", o_frame_valid); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int frames;
    frames = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_code_rate   = 1'($urandom);
      i_sym_valid   = ($urandom_range(0, 9) < 8);
      i_sym_data    = 3'($urandom);
      i_flush       = ($urandom_range(0, 99) < 2);
      i_frame_ready = ($urandom_range(0, 9) < 4);
      tick();
      checks++; if (o_sym_ready !== m_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, o_sym_ready, m_ready); end
      checks++; if (o_frame_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, o_frame_valid, m_valid); end
      if (m_valid) begin
        frames++;
        checks++; if (o_frame_len !== LEN_W'(m_len)) begin errors++; $display("FAIL rand_len cyc=%0d got=%0d exp=%0d", cyc, o_frame_len, m_len); end
        checks++; if (o_frame_data !== m_data) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, o_frame_data, m_data); end
      end
    end
    i_sym_valid = 1'b0; i_flush = 1'b0; i_frame_ready = 1'b0;
    checks++; if (frames == 0) begin errors++; $display("FAIL rand_frames got=0 exp=nonzero"); end
  endtask

  initial begin
    rst = 1'b1; i_code_rate = CODE_RATE_2; i_sym_valid = 1'b0; i_sym_data = '0;
    i_flush = 1'b0; i_frame_ready = 1'b0;
    m_hold = 1'b0; m_ready = 1'b0; m_valid = 1'b0; m_data = '0; m_len = 0; m_n = 2; m_acc = 0;
    test_reset();
    test_full_rate2();
    test_hold_rate3();
    test_flush_pattern();
    test_flush_empty_latch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
